// File: rtl/deser_pkg.sv
// Shared helpers for multilane_deserializer: beat/counter sizing and FIFO entry metadata.
// Optional macro DESER_PARITY_EN adds a parity-error bit to every FIFO entry.
package deser_pkg;

    function automatic int beats(input int data_width, input int lanes);
        return (lanes > 0) ? data_width / lanes : 1;
    endfunction

    function automatic int cnt_width(input int num_beats);
        return (num_beats <= 1) ? 1 : $clog2(num_beats);
    endfunction

    function automatic bit width_ok(input int data_width, input int lanes);
        return (lanes > 0) && (data_width >= lanes) && ((data_width % lanes) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

`ifdef DESER_PARITY_EN
    typedef struct packed {
        logic par_err;
    } entry_meta_t;
`endif

endpackage

// File: rtl/deser_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever o_empty is low.
// Generic over entry type; used by multilane_deserializer (any DESER_PARITY_EN setting).
module deser_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  T                         i_entry,
    input  logic                     i_pop,
    output T                         o_entry,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_level = cnt_q;
    assign o_entry = mem_q[rd_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_entry;
    end

endmodule

// File: rtl/multilane_deserializer.sv
// Gathers LANES-bit beats into DATA_WIDTH-bit words and queues them in an FWFT FIFO.
// Optional macro DESER_PARITY_EN adds i_parity / o_par_err.
module multilane_deserializer
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wen,
    input  logic [LANES-1:0]              i_data,
    input  logic                          i_sof,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_overrun,
    output logic                          o_align_err,
`ifdef DESER_PARITY_EN
    input  logic                          i_parity,
    output logic                          o_par_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int BEATS = beats(DATA_WIDTH, LANES);
    localparam int CW    = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!width_ok(DATA_WIDTH, LANES)) begin : g_bad_width
        $error("DATA_WIDTH must be a non-zero multiple of LANES");
    end
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] word;
`ifdef DESER_PARITY_EN
        entry_meta_t           meta;
`endif
    } entry_t;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  asm_q, asm_d;
    logic                   overrun_q, overrun_d;
    logic                   align_q, align_d;
    logic [CW-1:0]          beat_idx;
    logic                   last_beat;
    logic                   push_req;
    logic                   fifo_full, fifo_empty, fifo_pop;
    entry_t                 entry_in, entry_out;

    // A start-of-word beat restarts assembly at beat 0 regardless of the counter.
    always_comb begin
        beat_idx  = i_sof ? '0 : cnt_q;
        last_beat = (beat_idx == LAST_BEAT);
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        if (i_wen) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_idx == CW'(b)) begin
                    if (MSB_FIRST) asm_d[DATA_WIDTH-LANES-b*LANES +: LANES] = i_data;
                    else           asm_d[b*LANES +: LANES]                  = i_data;
                end
            end
            cnt_d = last_beat ? '0 : beat_idx + 1'b1;
        end
    end

    always_comb begin
        push_req   = i_wen && last_beat;
        overrun_d  = push_req && fifo_full && !fifo_pop;
        align_d    = i_wen && i_sof && (cnt_q != '0);
        entry_in   = '0;
        entry_in.word = asm_d;
`ifdef DESER_PARITY_EN
        entry_in.meta.par_err = (^asm_d) ^ i_parity;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            overrun_q <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            overrun_q <= overrun_d;
            align_q   <= align_d;
        end
    end

    assign fifo_pop = !fifo_empty && i_ready;

    deser_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_req),
        .i_entry (entry_in),
        .i_pop   (fifo_pop),
        .o_entry (entry_out),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    assign o_data      = entry_out.word;
    assign o_valid     = !fifo_empty;
    assign o_overrun   = overrun_q;
    assign o_align_err = align_q;
`ifdef DESER_PARITY_EN
    assign o_par_err   = entry_out.meta.par_err;
`endif

endmodule

// File: tb/tb_multilane_deserializer.sv
// Directed self-checking bench for multilane_deserializer (1-lane and 2-lane builds).
// Parity checks are included when DESER_PARITY_EN is defined.
module tb_multilane_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wen, sof, ready;
    logic [0:0] din;
    logic [7:0] dout;
    logic       valid, overrun, alignErr;
    logic [1:0] level;

    logic       wen2, sof2, ready2;
    logic [1:0] din2;
    logic [7:0] doutA, doutB;
    logic       validA, validB, ovA, ovB, alA, alB;
    logic [1:0] levelA, levelB;

`ifdef DESER_PARITY_EN
    logic       par, par2, parErr, parErrA, parErrB;
`endif

    int checkCount  = 0;
    int errorCount  = 0;
    int alignPulses = 0;
    int validCycles = 0;

    always #5 clk = ~clk;

    multilane_deserializer #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_data(din), .i_sof(sof),
        .o_data(dout), .o_valid(valid), .i_ready(ready),
        .o_overrun(overrun), .o_align_err(alignErr),
`ifdef DESER_PARITY_EN
        .i_parity(par), .o_par_err(parErr),
`endif
        .o_level(level)
    );

    multilane_deserializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1'b0), .FIFO_DEPTH(2)) dutLsb (
        .i_clk(clk), .i_rst(rst), .i_wen(wen2), .i_data(din2), .i_sof(sof2),
        .o_data(doutA), .o_valid(validA), .i_ready(ready2),
        .o_overrun(ovA), .o_align_err(alA),
`ifdef DESER_PARITY_EN
        .i_parity(par2), .o_par_err(parErrA),
`endif
        .o_level(levelA)
    );

    multilane_deserializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1'b1), .FIFO_DEPTH(2)) dutMsb (
        .i_clk(clk), .i_rst(rst), .i_wen(wen2), .i_data(din2), .i_sof(sof2),
        .o_data(doutB), .o_valid(validB), .i_ready(ready2),
        .o_overrun(ovB), .o_align_err(alB),
`ifdef DESER_PARITY_EN
        .i_parity(par2), .o_par_err(parErrB),
`endif
        .o_level(levelB)
    );

    // Pulse/word counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (alignErr) alignPulses++;
        if (valid)    validCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic d, input logic s);
        wen = w;
        din = d;
        sof = s;
        tick();
    endtask

    // Eight LSB-first beats; i_ready takes lastReady on the final beat.
    task automatic sendWord(input logic [7:0] w, input logic sofFirst, input logic lastReady);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready = lastReady;
            applyStimulus(1'b1, w[i], sofFirst && (i == 0));
        end
        wen = 1'b0;
        sof = 1'b0;
    endtask

    initial begin
        int a0, v0;
        logic [7:0] lanePat [4];
        lanePat[0] = 8'd1; lanePat[1] = 8'd2; lanePat[2] = 8'd3; lanePat[3] = 8'd0;

        rst = 1'b1; wen = 1'b0; sof = 1'b0; din = '0; ready = 1'b1;
        wen2 = 1'b0; sof2 = 1'b0; din2 = '0; ready2 = 1'b1;
`ifdef DESER_PARITY_EN
        par = 1'b0; par2 = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        checkOutput("reset valid", {31'd0, valid}, 32'd0);
        checkOutput("reset level", {30'd0, level}, 32'd0);
        checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset align", {31'd0, alignErr}, 32'd0);

        // Two-lane placement, both bit orders.
        for (int i = 0; i < 4; i++) begin
            wen2 = 1'b1;
            din2 = lanePat[i][1:0];
            tick();
        end
        wen2 = 1'b0;
        checkOutput("lsb2 valid", {31'd0, validA}, 32'd1);
        checkOutput("lsb2 data", {24'd0, doutA}, 32'h39);
        checkOutput("msb2 valid", {31'd0, validB}, 32'd1);
        checkOutput("msb2 data", {24'd0, doutB}, 32'h6C);
        tick();

        // Single word, ready high: visible exactly one cycle.
        v0 = validCycles;
        sendWord(8'hA5, 1'b0, 1'b1);
        checkOutput("a5 valid", {31'd0, valid}, 32'd1);
        checkOutput("a5 data", {24'd0, dout}, 32'hA5);
        tick();
        checkOutput("a5 gone", {31'd0, valid}, 32'd0);
        checkOutput("a5 one cycle", v0 == 0 ? validCycles : validCycles - v0, 32'd1);

        // Overrun with stalled consumer.
        ready = 1'b0;
        sendWord(8'h11, 1'b0, 1'b0);
        checkOutput("ovr level1", {30'd0, level}, 32'd1);
        sendWord(8'h22, 1'b0, 1'b0);
        checkOutput("ovr level2", {30'd0, level}, 32'd2);
        checkOutput("ovr none yet", {31'd0, overrun}, 32'd0);
        sendWord(8'h33, 1'b0, 1'b0);
        checkOutput("ovr pulse", {31'd0, overrun}, 32'd1);
        checkOutput("ovr level full", {30'd0, level}, 32'd2);
        tick();
        checkOutput("ovr pulse end", {31'd0, overrun}, 32'd0);
        ready = 1'b1;
        checkOutput("drain first", {24'd0, dout}, 32'h11);
        tick();
        checkOutput("drain second", {24'd0, dout}, 32'h22);
        tick();
        checkOutput("drain empty", {31'd0, valid}, 32'd0);
        checkOutput("drain level", {30'd0, level}, 32'd0);

        // Full FIFO with a pop on the completing beat.
        ready = 1'b0;
        sendWord(8'h44, 1'b0, 1'b0);
        sendWord(8'h55, 1'b0, 1'b0);
        checkOutput("full level", {30'd0, level}, 32'd2);
        sendWord(8'h66, 1'b0, 1'b1);
        checkOutput("pushpop overrun", {31'd0, overrun}, 32'd0);
        checkOutput("pushpop level", {30'd0, level}, 32'd2);
        checkOutput("pushpop head", {24'd0, dout}, 32'h55);
        tick();
        checkOutput("pushpop next", {24'd0, dout}, 32'h66);
        tick();
        checkOutput("pushpop empty", {31'd0, valid}, 32'd0);

        // Realignment: three stray beats then a start-of-word.
        ready = 1'b1;
        a0 = alignPulses;
        v0 = validCycles;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        sendWord(8'hC3, 1'b1, 1'b1);
        checkOutput("align data", {24'd0, dout}, 32'hC3);
        checkOutput("align valid", {31'd0, valid}, 32'd1);
        tick();
        checkOutput("align pulses", alignPulses - a0, 32'd1);
        checkOutput("align words", validCycles - v0, 32'd1);

        // Reset mid-word with one word queued.
        ready = 1'b0;
        sendWord(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        wen = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("rst valid", {31'd0, valid}, 32'd0);
        checkOutput("rst level", {30'd0, level}, 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        sendWord(8'h5A, 1'b0, 1'b1);
        checkOutput("post rst valid", {31'd0, valid}, 32'd1);
        checkOutput("post rst data", {24'd0, dout}, 32'h5A);
        tick();

`ifdef DESER_PARITY_EN
        par = 1'b0;
        sendWord(8'h07, 1'b0, 1'b1);
        checkOutput("parity bad", {31'd0, parErr}, 32'd1);
        tick();
        par = 1'b1;
        sendWord(8'h07, 1'b0, 1'b1);
        checkOutput("parity good", {31'd0, parErr}, 32'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
